// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: filtered halls -> sector/step count -> dead-timed, PWM-gated half-bridge drives.
// Latency: hall edge to accepted code 2+HALL_FILTER cycles, gates registered (pwm_in 1 cycle); no backpressure.
module bldc_commutator #(
   parameter int DEADTIME_CYCLES = 32,
   parameter int HALL_FILTER     = 3,
   parameter int STALL_CYCLES    = 3_200_000
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               enable,
   input  logic               dir,
   input  logic               pwm_in,
   input  logic [2:0]         hall,
   output logic               INHA,
   output logic               INLA,
   output logic               INHB,
   output logic               INLB,
   output logic               INHC,
   output logic               INLC,
   output logic [2:0]         sector,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic signed [23:0] step_count
);

   localparam int FW = $clog2(HALL_FILTER + 1);
   localparam int DW = $clog2(DEADTIME_CYCLES + 1);
   localparam int SW = $clog2(STALL_CYCLES + 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEADTIME = 2'd1;
   localparam logic [1:0] DRIVE    = 2'd2;
   localparam logic [1:0] FAULT    = 2'd3;

   function automatic logic [2:0] hall_sector(input logic [2:0] code);
      case (code)
         3'b101:  return 3'd0;
         3'b100:  return 3'd1;
         3'b110:  return 3'd2;
         3'b010:  return 3'd3;
         3'b011:  return 3'd4;
         3'b001:  return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic hall_ok(input logic [2:0] code);
      return (code != 3'b000) && (code != 3'b111);
   endfunction

   logic [2:0]    hall_m, hall_s, filt_code, acc_code;
   logic [FW-1:0] filt_cnt, filt_nxt;
   logic          accept, acc_chg, acc_vld;
   logic [2:0]    new_sec, sec_inc, sec_dec;

   logic [1:0]    state;
   logic [DW-1:0] dt_cnt;
   logic [SW-1:0] stall_cnt;
   logic [2:0]    sec_q;
   logic          dir_q;
   logic [5:0]    gates, drv;
   logic [2:0]    fwd_hi, fwd_lo, hi_oh, lo_oh;

   always_comb begin
      filt_nxt = FW'(1);
      if (hall_s == filt_code)
         filt_nxt = (filt_cnt == FW'(HALL_FILTER)) ? filt_cnt : filt_cnt + FW'(1);
   end

   assign accept  = (filt_nxt == FW'(HALL_FILTER)) && (hall_s != acc_code);
   assign acc_vld = hall_ok(acc_code);
   assign new_sec = hall_sector(hall_s);
   assign sec_inc = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
   assign sec_dec = (sector == 3'd0) ? 3'd5 : sector - 3'd1;

   // Steps are only counted between two valid codes; loading from 000/111 just sets the sector.
   always_ff @(posedge CLK) begin
      if (reset) begin
         hall_m     <= 3'b000;
         hall_s     <= 3'b000;
         filt_code  <= 3'b000;
         filt_cnt   <= '0;
         acc_code   <= 3'b000;
         acc_chg    <= 1'b0;
         sector     <= 3'd0;
         step_count <= '0;
      end else begin
         hall_m    <= hall;
         hall_s    <= hall_m;
         filt_code <= hall_s;
         filt_cnt  <= filt_nxt;
         acc_chg   <= accept;
         if (accept) begin
            acc_code <= hall_s;
            if (hall_ok(hall_s)) begin
               sector <= new_sec;
               if (acc_vld && new_sec == sec_inc)
                  step_count <= step_count + 24'sd1;
               else if (acc_vld && new_sec == sec_dec)
                  step_count <= step_count - 24'sd1;
            end
         end
      end
   end

   // One-hot legs {A,B,C}; reverse simply swaps the high and low leg.
   always_comb begin
      fwd_hi = 3'b000;
      fwd_lo = 3'b000;
      case (sector)
         3'd0: begin fwd_hi = 3'b100; fwd_lo = 3'b010; end
         3'd1: begin fwd_hi = 3'b100; fwd_lo = 3'b001; end
         3'd2: begin fwd_hi = 3'b010; fwd_lo = 3'b001; end
         3'd3: begin fwd_hi = 3'b010; fwd_lo = 3'b100; end
         3'd4: begin fwd_hi = 3'b001; fwd_lo = 3'b100; end
         3'd5: begin fwd_hi = 3'b001; fwd_lo = 3'b010; end
         default: ;
      endcase
      hi_oh = dir ? fwd_lo : fwd_hi;
      lo_oh = dir ? fwd_hi : fwd_lo;
      drv   = {hi_oh[2] & pwm_in, lo_oh[2], hi_oh[1] & pwm_in, lo_oh[1],
               hi_oh[0] & pwm_in, lo_oh[0]};
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= IDLE;
         dt_cnt     <= '0;
         stall_cnt  <= '0;
         sec_q      <= 3'd0;
         dir_q      <= 1'b0;
         gates      <= '0;
         fault      <= 1'b0;
         fault_code <= 2'd0;
      end else begin
         gates     <= '0;
         stall_cnt <= '0;
         case (state)
            IDLE: begin
               if (enable && acc_vld) begin
                  state  <= DEADTIME;
                  dt_cnt <= '0;
                  sec_q  <= sector;
                  dir_q  <= dir;
               end
            end
            DEADTIME: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (!acc_vld) begin
                  state      <= FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'd1;
               end else if (sector != sec_q || dir != dir_q) begin
                  dt_cnt <= '0;
                  sec_q  <= sector;
                  dir_q  <= dir;
               end else if (dt_cnt == DW'(DEADTIME_CYCLES - 1)) begin
                  state <= DRIVE;
                  gates <= drv;
               end else begin
                  dt_cnt <= dt_cnt + DW'(1);
               end
            end
            DRIVE: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (!acc_vld) begin
                  state      <= FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'd1;
               end else if (sector != sec_q || dir != dir_q) begin
                  state  <= DEADTIME;
                  dt_cnt <= '0;
                  sec_q  <= sector;
                  dir_q  <= dir;
               end else if (stall_cnt == SW'(STALL_CYCLES - 1)) begin
                  state      <= FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'd2;
               end else begin
                  gates     <= drv;
                  stall_cnt <= acc_chg ? '0 : stall_cnt + SW'(1);
               end
            end
            FAULT: begin
               if (!enable) begin
                  state      <= IDLE;
                  fault      <= 1'b0;
                  fault_code <= 2'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign {INHA, INLA, INHB, INLB, INHC, INLC} = gates;

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_bldc_commutator;

   logic clk32MHz = 1'b0;
   always #5 clk32MHz = ~clk32MHz;

   logic               reset, enable, dir, pwm_in;
   logic [2:0]         hall;
   logic               INHA, INLA, INHB, INLB, INHC, INLC;
   logic [2:0]         sector;
   logic               fault;
   logic [1:0]         fault_code;
   logic signed [23:0] step_count;
   logic [5:0]         gates;

   assign gates = {INHA, INLA, INHB, INLB, INHC, INLC};

   bldc_commutator #(
      .DEADTIME_CYCLES(4),
      .HALL_FILTER    (3),
      .STALL_CYCLES   (100)
   ) dut (
      .CLK       (clk32MHz),
      .reset     (reset),
      .enable    (enable),
      .dir       (dir),
      .pwm_in    (pwm_in),
      .hall      (hall),
      .INHA      (INHA),
      .INLA      (INLA),
      .INHB      (INHB),
      .INLB      (INLB),
      .INHC      (INHC),
      .INLC      (INLC),
      .sector    (sector),
      .fault     (fault),
      .fault_code(fault_code),
      .step_count(step_count)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [5:0] g;
      logic [2:0] s;
      logic       f;
      logic [1:0] c;
      logic [23:0] st;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   mi;

   always @(posedge clk32MHz) cyc <= cyc + 1;

   // Gate order in every vector: {INHA,INLA,INHB,INLB,INHC,INLC}
   always @(negedge clk32MHz) begin
      checks++;
      if ((INHA && INLA) || (INHB && INLB) || (INHC && INLC)) begin
         errors++;
         $display("FAIL shoot_through cyc=%0d: gates=%b, required no leg with both high and low on", cyc, gates);
      end
      mi = 0;
      while (mi < sb.size()) begin
         if (sb[mi].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d was never sampled", sb[mi].name, sb[mi].cyc);
            sb.delete(mi);
         end else if (sb[mi].cyc == cyc) begin
            checks++;
            if ({gates, sector, fault, fault_code, step_count} !==
                {sb[mi].g, sb[mi].s, sb[mi].f, sb[mi].c, sb[mi].st}) begin
               errors++;
               $display("FAIL %s cyc=%0d: got gates=%b sector=%0d fault=%b code=%0d step=%0d, required gates=%b sector=%0d fault=%b code=%0d step=%0d",
                        sb[mi].name, cyc, gates, sector, fault, fault_code, step_count,
                        sb[mi].g, sb[mi].s, sb[mi].f, sb[mi].c, $signed(sb[mi].st));
            end
            sb.delete(mi);
         end else begin
            mi++;
         end
      end
   end

   task automatic expect_at(input int dt, input string nm, input logic [5:0] g, input logic [2:0] s,
                            input logic f, input logic [1:0] c, input int st);
      exp_t e;
      e.cyc  = cyc + dt;
      e.name = nm;
      e.g    = g;
      e.s    = s;
      e.f    = f;
      e.c    = c;
      e.st   = st[23:0];
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk32MHz);
   endtask

   // Hall edge at this negedge: accepted 5 edges later, 4 dead cycles, new drive at +10.
   task automatic hall_step(input logic [2:0] code, input logic [2:0] s, input int st,
                            input logic [5:0] g_old, input logic [5:0] g_new, input string nm);
      hall = code;
      expect_at(5, {nm, "_accept"}, g_old, s, 1'b0, 2'd0, st);
      for (int k = 6; k <= 9; k++) expect_at(k, {nm, "_dead"}, 6'b000000, s, 1'b0, 2'd0, st);
      expect_at(10, {nm, "_drive"}, g_new, s, 1'b0, 2'd0, st);
      wait_cyc(20);
   endtask

   // Dir flip while driving: dead time starts on the next edge, new drive at +5.
   task automatic dir_flip(input logic d, input logic [2:0] s, input int st,
                           input logic [5:0] g_new, input string nm);
      dir = d;
      expect_at(1, {nm, "_dead0"}, 6'b000000, s, 1'b0, 2'd0, st);
      expect_at(4, {nm, "_dead3"}, 6'b000000, s, 1'b0, 2'd0, st);
      expect_at(5, {nm, "_drive"}, g_new, s, 1'b0, 2'd0, st);
      wait_cyc(10);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      dir    = 1'b0;
      pwm_in = 1'b1;
      hall   = 3'b000;
      expect_at(1, "reset_state", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(3);
      reset = 1'b0;
      expect_at(1, "post_reset", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(2);

      // Start-up from idle into S0 forward
      enable = 1'b1;
      hall   = 3'b101;
      expect_at(4, "start_pre_accept", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      expect_at(6, "start_dead0", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      expect_at(9, "start_dead3", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      expect_at(10, "start_s0", 6'b100100, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(12);
      pwm_in = 1'b0;
      expect_at(1, "pwm_low", 6'b000100, 3'd0, 1'b0, 2'd0, 0);
      expect_at(2, "pwm_low_hold", 6'b000100, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(2);
      pwm_in = 1'b1;
      expect_at(1, "pwm_high", 6'b100100, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(2);

      // Forward rotation
      hall_step(3'b100, 3'd1, 1, 6'b100100, 6'b100001, "fwd_s1");
      hall_step(3'b110, 3'd2, 2, 6'b100001, 6'b001001, "fwd_s2");
      hall_step(3'b010, 3'd3, 3, 6'b001001, 6'b011000, "fwd_s3");
      hall_step(3'b011, 3'd4, 4, 6'b011000, 6'b010010, "fwd_s4");
      hall_step(3'b001, 3'd5, 5, 6'b010010, 6'b000110, "fwd_s5");
      hall_step(3'b101, 3'd0, 6, 6'b000110, 6'b100100, "fwd_s0");

      // Reset pulse mid-drive, then restart in reverse
      reset = 1'b1;
      expect_at(1, "reset_mid_drive", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(1);
      reset = 1'b0;
      dir   = 1'b1;
      expect_at(4, "rev_pre_accept", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      expect_at(9, "rev_dead3", 6'b000000, 3'd0, 1'b0, 2'd0, 0);
      expect_at(10, "rev_s0_start", 6'b011000, 3'd0, 1'b0, 2'd0, 0);
      wait_cyc(14);

      // Reverse rotation
      hall_step(3'b001, 3'd5, -1, 6'b011000, 6'b001001, "rev_s5");
      hall_step(3'b011, 3'd4, -2, 6'b001001, 6'b100001, "rev_s4");
      hall_step(3'b010, 3'd3, -3, 6'b100001, 6'b100100, "rev_s3");
      hall_step(3'b110, 3'd2, -4, 6'b100100, 6'b000110, "rev_s2");
      hall_step(3'b100, 3'd1, -5, 6'b000110, 6'b010010, "rev_s1");
      hall_step(3'b101, 3'd0, -6, 6'b010010, 6'b011000, "rev_s0");

      // Two-cycle glitch must be filtered out
      hall = 3'b100;
      expect_at(3, "glitch_a", 6'b011000, 3'd0, 1'b0, 2'd0, -6);
      expect_at(6, "glitch_b", 6'b011000, 3'd0, 1'b0, 2'd0, -6);
      expect_at(10, "glitch_c", 6'b011000, 3'd0, 1'b0, 2'd0, -6);
      expect_at(13, "glitch_d", 6'b011000, 3'd0, 1'b0, 2'd0, -6);
      wait_cyc(2);
      hall = 3'b101;
      wait_cyc(12);

      // Back to forward, step to S2, then flip direction in S2
      dir_flip(1'b0, 3'd0, -6, 6'b100100, "dir_fwd_s0");
      hall_step(3'b100, 3'd1, -5, 6'b100100, 6'b100001, "fwd2_s1");
      hall_step(3'b110, 3'd2, -4, 6'b100001, 6'b001001, "fwd2_s2");
      dir_flip(1'b1, 3'd2, -4, 6'b000110, "dir_rev_s2");

      // Invalid hall code while driving
      hall = 3'b111;
      expect_at(5, "inv_accept", 6'b000110, 3'd2, 1'b0, 2'd0, -4);
      expect_at(6, "inv_fault", 6'b000000, 3'd2, 1'b1, 2'd1, -4);
      expect_at(10, "inv_fault_hold", 6'b000000, 3'd2, 1'b1, 2'd1, -4);
      wait_cyc(12);
      enable = 1'b0;
      expect_at(1, "inv_clear", 6'b000000, 3'd2, 1'b0, 2'd0, -4);
      wait_cyc(2);
      enable = 1'b1;
      expect_at(3, "idle_on_invalid", 6'b000000, 3'd2, 1'b0, 2'd0, -4);
      wait_cyc(4);

      // Reload from 111 (no step counted), then stall with hall held
      hall = 3'b010;
      expect_at(5, "reload_s3", 6'b000000, 3'd3, 1'b0, 2'd0, -4);
      expect_at(9, "reload_dead3", 6'b000000, 3'd3, 1'b0, 2'd0, -4);
      expect_at(10, "reload_drive", 6'b100100, 3'd3, 1'b0, 2'd0, -4);
      expect_at(109, "stall_last_drive", 6'b100100, 3'd3, 1'b0, 2'd0, -4);
      expect_at(110, "stall_fault", 6'b000000, 3'd3, 1'b1, 2'd2, -4);
      wait_cyc(112);
      enable = 1'b0;
      expect_at(1, "stall_clear", 6'b000000, 3'd3, 1'b0, 2'd0, -4);
      wait_cyc(3);

      for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk32MHz);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending: %0d expectations left unsampled, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step commutation controller sequencing the three half-bridge gate drivers (INHA..INLC) of the motor board from the hall sensors, the PWM output and the direction bit.
- Inserts a dead time on every commutation or direction change, filters hall glitches, and detects invalid hall codes and stalls.
- Tracks electrical steps in a signed counter.
- Sits between the hall SB_IO inputs, the pwm block output and the gate pins, replacing direct pin assignments.

Parameters:
- DEADTIME_CYCLES, 32, all-gates-off cycles on each commutation (1 us at 32 MHz)
- HALL_FILTER, 3, consecutive identical synchronized samples needed to accept a hall code (>=1)
- STALL_CYCLES, 3_200_000, cycles without an accepted hall change while driving before stall fault (100 ms)

Ports:
- CLK  in  1  system clock (clk32MHz)
- reset  in  1  synchronous, active-high reset
- enable  in  1  drive request; 0 forces IDLE
- dir  in  1  0 = forward, 1 = reverse
- pwm_in  in  1  PWM from pwm block
- hall  in  3  {hall3,hall2,hall1}, asynchronous
- INHA, INLA, INHB, INLB, INHC, INLC  out  1 each  gate drives, registered
- sector  out  3  current sector 0..5
- fault  out  1  latched fault
- fault_code  out  2  0 none, 1 invalid hall, 2 stall
- step_count  out  24  signed electrical step count

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous and active-high, port named reset.
- Reset values:
  - all gates 0, sector 0, fault 0, fault_code 0, step_count 0
  - state IDLE, filter and timers 0
  - the hall code accepted at reset is 000; the first valid code is an initial sector load
- Hall input path:
  - hall passes through a 2-FF synchronizer.
  - A filter counter tracks the synchronized value. The accepted code updates when the same value has been seen HALL_FILTER consecutive cycles.
  - With a clean step at the input, the accepted code changes on the (2+HALL_FILTER)th rising edge.
- Hall code to sector map: 101->0, 100->1, 110->2, 010->3, 011->4, 001->5. Accepted codes 000 and 111 are invalid.
- Step counting on each accepted valid change:
  - new = old+1 mod 6: step_count +1
  - new = old-1 mod 6: step_count -1
  - any other jump: count unchanged, sector still updates
  - step_count wraps in two's complement
  - the initial load from 000 does not count
- Drive table, forward (high-side gated by pwm_in, low-side static on, third leg all off):
  - S0: A high, B low
  - S1: A high, C low
  - S2: B high, C low
  - S3: B high, A low
  - S4: C high, A low
  - S5: C high, B low
- Drive table, reverse: the same sector drives the swapped pair (S0: B high, A low, etc.).
- Invariant: INHx and INLx are never 1 together for any phase.
- State IDLE:
  - all gates 0
  - enable=1 and the accepted code is valid -> DEADTIME
- State DEADTIME:
  - all gates 0; counter runs DEADTIME_CYCLES cycles, then -> DRIVE
  - a sector or dir change during DEADTIME restarts the counter
- State DRIVE:
  - gates are registered from the table, so the high-side follows pwm_in with 1 cycle latency
  - sector change or dir change -> DEADTIME; the gates are 0 on the very next cycle
- State FAULT:
  - all gates 0, fault=1
  - exits to IDLE only when enable=0, which also clears fault and fault_code
- Fault entry:
  - an accepted invalid code in DEADTIME or DRIVE -> FAULT, fault_code=1
  - stall timer: counts in DRIVE, clears on any accepted change and outside DRIVE; reaching STALL_CYCLES -> FAULT, fault_code=2
  - invalid code and stall in the same cycle: code 1 wins
- enable=0 in any non-FAULT state -> IDLE next cycle, gates 0.
- Reset asserted mid-drive: gates 0 on the next edge; step_count cleared.

Test Plan (bench params DEADTIME_CYCLES=4, HALL_FILTER=3, STALL_CYCLES=100):
- Reset, then enable=1, hall=101, pwm_in=1, dir=0:
  - sector=0 accepted at cycle 5
  - gates 0 for 4 cycles
  - then INHA=1, INLB=1, all other gates 0
  - pwm_in=0 -> INHA=0 one cycle later, INLB stays 1
- Forward rotation 101,100,110,010,011,001,101, each held 20 cycles:
  - step_count=+6
  - each transition shows exactly 4 all-zero gate cycles
  - INHx and INLx never both 1
- Reverse sequence of the same codes with dir=1:
  - step_count=-6
  - in S0 the drive is INHB=1, INLA=1
- 2-cycle glitch 101->100->101 on hall: sector stays 0, no dead time, step_count unchanged.
- Fault scenarios:
  - hall=111 held while driving -> fault=1, fault_code=1, all gates 0
  - enable=0 -> IDLE, fault=0
  - hall held constant in DRIVE for 100 cycles -> fault_code=2
- Dir toggle in DRIVE S2 -> 4 all-zero cycles, then INHC=1, INLB=1. Reset pulsed during DRIVE -> all gates 0 and step_count=0 on the next edge.
